// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC, in-order pipelined imem requests, head-of-queue to decode.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_queue_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 QDEPTH   = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              is_branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_flush_cnt,
  output logic [15:0]       perf_starve_cnt
`endif
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [15:0]       instr_mem_q [QDEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [QDEPTH];

  logic              fetch_ok;
  logic              resp;
  logic              push;
  logic              pop;
  logic [SUM_W-1:0]  inflight;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    inflight = SUM_W'(count_q) + SUM_W'(out_q);
    fetch_ok = (state_q == ST_RUN) && (inflight < SUM_W'(QDEPTH)) && !is_branch_taken;
    // A response with nothing outstanding is a leftover from before reset.
    resp     = imem_valid && (out_q != '0);
    push     = resp && !is_branch_taken && (discard_q == '0);
    pop      = (count_q != '0) && !stall && !is_branch_taken;

    state_d   = state_q;
    pc_d      = pc_q;
    ret_pc_d  = ret_pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    out_d     = out_q + CNT_W'(fetch_ok) - CNT_W'(resp);
    discard_d = discard_q;

    if (fetch_ok) pc_d = pc_q + ADDR_W'(1);

    if (is_branch_taken) begin
      state_d   = ST_REDIR;
      pc_d      = branch_target;
      ret_pc_d  = branch_target;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      discard_d = out_q - CNT_W'(resp);
    end else begin
      if (state_q != ST_RUN) state_d = ST_RUN;
      if (resp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
      if (push) begin
        tail_d   = tail_q + PTR_W'(1);
        ret_pc_d = ret_pc_q + ADDR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      ret_pc_q  <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ret_pc_q  <= ret_pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      out_q     <= out_d;
      discard_q <= discard_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[tail_q] <= imem_rdata;
      pc_mem_q[tail_q]    <= ret_pc_q;
    end
  end

  assign imem_req    = fetch_ok;
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? instr_mem_q[head_q] : 16'h0000;
  assign instr_pc    = instr_valid ? pc_mem_q[head_q]    : '0;

`ifdef FETCH_PERF_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (is_branch_taken && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    if ((state_q == ST_RUN) && !instr_valid && !stall && (starve_cnt_q != 16'hFFFF))
      starve_cnt_d = starve_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_starve_cnt = starve_cnt_q;
`endif

endmodule
